// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle for axil_cmd_master: master drives addresses/data/VALIDs,
// slave drives READYs and responses.
interface axil_cmd_master_if #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 9
);
    logic [AXIL_ADDR_WIDTH-1:0]   AWADDR;
    logic                         AWVALID;
    logic                         AWREADY;
    logic [AXIL_DATA_WIDTH-1:0]   WDATA;
    logic [AXIL_DATA_WIDTH/8-1:0] WSTRB;
    logic                         WVALID;
    logic                         WREADY;
    logic [1:0]                   BRESP;
    logic                         BVALID;
    logic                         BREADY;
    logic [AXIL_ADDR_WIDTH-1:0]   ARADDR;
    logic                         ARVALID;
    logic                         ARREADY;
    logic [AXIL_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                   RRESP;
    logic                         RVALID;
    logic                         RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one register command at a time becomes one AXI4-Lite
// write or read; the response and its status are handed back to the requester.
module axil_cmd_master #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 9,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_write,
    output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic [31:0]                  txn_count,
    output logic [15:0]                  err_count,
    output logic                         timeout_err,
    axil_cmd_master_if.master            M_AXIL
);

    localparam int          SW     = AXIL_DATA_WIDTH / 8;
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);
    localparam logic        TO_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WB,
        S_RA,
        S_RD,
        S_RSP
    } state_t;

    state_t                       state_q, state_d;
    logic                         write_q, write_d;
    logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]                wstrb_q, wstrb_d;
    logic                         awvalid_q, awvalid_d;
    logic                         wvalid_q, wvalid_d;
    logic                         bready_q, bready_d;
    logic                         arvalid_q, arvalid_d;
    logic                         rready_q, rready_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [AXIL_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                   resp_q, resp_d;
    logic [31:0]                  txn_q, txn_d;
    logic [15:0]                  err_q, err_d;
    logic [31:0]                  wait_q, wait_d;
    logic                         timeout_q, timeout_d;
    logic                         in_wait;

    assign cmd_ready = (state_q == S_IDLE) && !ap_rst;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            txn_q       <= '0;
            err_q       <= '0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            txn_q       <= txn_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        txn_d       = txn_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RA;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; a low VALID here means that channel is done.
                if (awvalid_q && M_AXIL.AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXIL.WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (bready_q && M_AXIL.BVALID) begin
                    bready_d    = 1'b0;
                    resp_d      = M_AXIL.BRESP;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RA: begin
                if (arvalid_q && M_AXIL.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (rready_q && M_AXIL.RVALID) begin
                    rready_d    = 1'b0;
                    rdata_d     = M_AXIL.RDATA;
                    resp_d      = M_AXIL.RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_d       = txn_q + 32'd1;
                    if (resp_q != 2'b00 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter restarts on every state change; the flag only reports, it never aborts.
    always_comb begin
        in_wait   = (state_q == S_WR) || (state_q == S_WB) ||
                    (state_q == S_RA) || (state_q == S_RD);
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if (!in_wait || state_d != state_q) begin
            wait_d = '0;
        end else begin
            if (wait_q != TO_LIM) wait_d = wait_q + 32'd1;
            if (TO_EN && wait_q == TO_LIM - 32'd1) timeout_d = 1'b1;
        end
    end

    assign M_AXIL.AWADDR  = addr_q;
    assign M_AXIL.AWVALID = awvalid_q;
    assign M_AXIL.WDATA   = wdata_q;
    assign M_AXIL.WSTRB   = wstrb_q;
    assign M_AXIL.WVALID  = wvalid_q;
    assign M_AXIL.BREADY  = bready_q;
    assign M_AXIL.ARADDR  = addr_q;
    assign M_AXIL.ARVALID = arvalid_q;
    assign M_AXIL.RREADY  = rready_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign txn_count   = txn_q;
    assign err_count   = err_q;
    assign timeout_err = timeout_q;

    a_aw_hold: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (awvalid_q && !M_AXIL.AWREADY) |=> (awvalid_q && $stable(addr_q)));
    a_w_hold: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (wvalid_q && !M_AXIL.WREADY) |=> (wvalid_q && $stable(wdata_q) && $stable(wstrb_q)));
    a_ar_hold: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (arvalid_q && !M_AXIL.ARREADY) |=> (arvalid_q && $stable(addr_q)));
    a_rsp_hold: assert property (@(posedge ap_clk) disable iff (ap_rst)
        (rsp_valid_q && !rsp_ready) |=> (rsp_valid_q && $stable(rdata_q) && $stable(resp_q)));

endmodule
